// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one registered ALU: round robin (fixed priority with ALU_ARB_FIXED_PRIO_EN), done 3 cycles after grant.
// Requests are only sampled in IDLE; a held req waits without loss, one operation per 4 cycles.
module alu_arbiter #(
    parameter int DW = 16,
    parameter int FW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [FW-1:0] func0,
    input  logic          req1,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    input  logic [FW-1:0] func1,
    output logic [1:0]    gnt,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] res,
    output logic          busy,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [FW-1:0] alu_func,
    output logic          alu_en,
    input  logic [DW-1:0] alu_res
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [DW-1:0] res_q, res_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [FW-1:0] func_q, func_d;
    logic          win1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign win1 = !req0;
`else
    // last_q names the requester granted most recently; the other one wins a tie.
    logic last_q, last_d;
    assign win1 = (req0 && req1) ? !last_q : req1;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        res_d   = res_q;
        a_d     = a_q;
        b_d     = b_q;
        func_d  = func_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ISSUE;
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    a_d     = win1 ? a1 : a0;
                    b_d     = win1 ? b1 : b0;
                    func_d  = win1 ? func1 : func0;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = win1;
`endif
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                res_d   = alu_res;
                state_d = DONE;
            end
            DONE: begin
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            res_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            func_q  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            res_q   <= res_d;
            a_q     <= a_d;
            b_q     <= b_d;
            func_q  <= func_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done0    = (state_q == DONE) && gnt_q[0];
    assign done1    = (state_q == DONE) && gnt_q[1];
    assign res      = res_q;
    assign busy     = (state_q != IDLE);
    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_func = func_q;
    assign alu_en   = (state_q == ISSUE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a one-cycle registered ALU model alongside.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic [2:0]  func0, func1;
    logic [1:0]  gnt;
    logic        done0, done1, busy, alu_en;
    logic [15:0] res, alu_a, alu_b, alu_res;
    logic [2:0]  alu_func;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.DW(16), .FW(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .func0(func0),
        .req1(req1), .a1(a1), .b1(b1), .func1(func1),
        .gnt(gnt), .done0(done0), .done1(done1), .res(res), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_en(alu_en),
        .alu_res(alu_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU: result appears the cycle after enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) alu_res <= '0;
        else if (alu_en) begin
            case (alu_func)
                3'b001:  alu_res <= alu_a + alu_b;
                3'b010:  alu_res <= alu_a - alu_b;
                3'b011:  alu_res <= alu_a & alu_b;
                3'b100:  alu_res <= alu_a | alu_b;
                default: alu_res <= alu_a;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_en"}, 32'(alu_en), 32'h0);
        chk({tag, "_done"}, 32'({done1, done0}), 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; func0 = '0;
        a1 = '0; b1 = '0; func1 = '0;

        // Reset state
        step(); step();
        chk_idle("rst");
        chk("rst_res", 32'(res), 32'h0);
        chk("rst_alua", 32'(alu_a), 32'h0);
        chk("rst_alub", 32'(alu_b), 32'h0);
        chk("rst_func", 32'(alu_func), 32'h0);
        rst = 1'b1;
        step();
        chk_idle("idle0");

        // Single request, add
        req0 = 1'b1; a0 = 16'h0003; b0 = 16'h0004; func0 = 3'b001;
        step();
        chk("add_n1_gnt", 32'(gnt), 32'h1);
        chk("add_n1_en", 32'(alu_en), 32'h1);
        chk("add_n1_busy", 32'(busy), 32'h1);
        chk("add_n1_func", 32'(alu_func), 32'h1);
        step();
        chk("add_n2_gnt", 32'(gnt), 32'h1);
        chk("add_n2_en", 32'(alu_en), 32'h0);
        chk("add_n2_done", 32'({done1, done0}), 32'h0);
        step();
        chk("add_n3_gnt", 32'(gnt), 32'h1);
        chk("add_n3_done", 32'({done1, done0}), 32'h1);
        chk("add_n3_res", 32'(res), 32'h0007);
        chk("add_n3_en", 32'(alu_en), 32'h0);
        req0 = 1'b0;
        step();
        chk_idle("add_n4");
        chk("add_n4_res_hold", 32'(res), 32'h0007);
        chk("add_n4_alua_hold", 32'(alu_a), 32'h0003);

        // Tie after reset: requester 0 first, then requester 1
        rst = 1'b0;
        step();
        rst = 1'b1;
        req0 = 1'b1; a0 = 16'h0001; b0 = 16'h0002; func0 = 3'b001;
        req1 = 1'b1; a1 = 16'h000A; b1 = 16'h0003; func1 = 3'b010;
        step();
        chk("tie_gnt0", 32'(gnt), 32'h1);
        step(); step();
        chk("tie_done0", 32'({done1, done0}), 32'h1);
        chk("tie_res0", 32'(res), 32'h0003);
        req0 = 1'b0;
        step();
        chk_idle("tie_gap");
        step();
        chk("tie_gnt1", 32'(gnt), 32'h2);
        chk("tie_alua1", 32'(alu_a), 32'h000A);
        step(); step();
        chk("tie_done1", 32'({done1, done0}), 32'h2);
        chk("tie_res1", 32'(res), 32'h0007);
        req1 = 1'b0;
        step();

        // Both held: 8 operations
        req0 = 1'b1; a0 = 16'h0010; b0 = 16'h0001; func0 = 3'b001;
        req1 = 1'b1; a1 = 16'h0010; b1 = 16'h0001; func1 = 3'b010;
        for (int k = 0; k < 8; k++) begin
            logic w1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            w1 = 1'b0;
`else
            w1 = (k % 2) == 1;
`endif
            step();
            chk("rr_gnt", 32'(gnt), w1 ? 32'h2 : 32'h1);
            step(); step();
            chk("rr_done", 32'({done1, done0}), w1 ? 32'h2 : 32'h1);
            chk("rr_res", 32'(res), w1 ? 32'h000F : 32'h0011);
            step();
            chk("rr_idle_busy", 32'(busy), 32'h0);
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
`ifdef ALU_ARB_FIXED_PRIO_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
`endif

        // Request while busy, plus operand change after the grant edge
        req0 = 1'b1; a0 = 16'h0005; b0 = 16'h0007; func0 = 3'b010;
        step();
        chk("bsy_gnt0", 32'(gnt), 32'h1);
        req1 = 1'b1; a1 = 16'h0002; b1 = 16'h0003; func1 = 3'b001;
        a0 = 16'hFFFF;
        step();
        chk("bsy_gnt_hold", 32'(gnt), 32'h1);
        chk("bsy_alua_hold", 32'(alu_a), 32'h0005);
        step();
        chk("bsy_done0", 32'({done1, done0}), 32'h1);
        chk("bsy_res0", 32'(res), 32'hFFFE);
        req0 = 1'b0;
        step();
        chk_idle("bsy_idle");
        step();
        chk("bsy_gnt1", 32'(gnt), 32'h2);
        chk("bsy_en1", 32'(alu_en), 32'h1);
        step(); step();
        chk("bsy_done1", 32'({done1, done0}), 32'h2);
        chk("bsy_res1", 32'(res), 32'h0005);
        req1 = 1'b0;
        step();

        // Reset in CAPTURE
        req0 = 1'b1; a0 = 16'h0100; b0 = 16'h0023; func0 = 3'b001;
        step(); step();
        chk("rc_pre_gnt", 32'(gnt), 32'h1);
        rst = 1'b0;
        #1;
        chk_idle("rc_abort");
        chk("rc_res", 32'(res), 32'h0);
        chk("rc_alua", 32'(alu_a), 32'h0);
        step();
        chk("rc_nodone", 32'({done1, done0}), 32'h0);
        rst = 1'b1;
        step();
        chk("rc_re_gnt", 32'(gnt), 32'h1);
        chk("rc_re_en", 32'(alu_en), 32'h1);
        step();
        chk("rc_re_cap", 32'({done1, done0}), 32'h0);
        step();
        chk("rc_re_done", 32'({done1, done0}), 32'h1);
        chk("rc_re_res", 32'(res), 32'h0123);
        req0 = 1'b0;
        step();
        chk_idle("rc_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 16-bit registered ALU between two requesters (e.g. the execute stage and a secondary address/debug unit).
- Arbitrates requests, registers the winner's operands and function code, and drives the ALU enable for exactly one cycle.
- Captures the ALU result and returns it to the winner with a one-cycle done pulse.
- Sits between the requesters and the ALU. It drives the ALU's operand, function and enable inputs and reads the ALU's result output.

Parameters:
- DW, 16, operand/result width; must match the ALU width.
- FW, 3, function code width; must match the ALU function code.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  requester 0 operation request, level.
- a0  in  DW  requester 0 operand A.
- b0  in  DW  requester 0 operand B.
- func0  in  FW  requester 0 ALU function code.
- req1  in  1  requester 1 operation request, level.
- a1  in  DW  requester 1 operand A.
- b1  in  DW  requester 1 operand B.
- func1  in  FW  requester 1 ALU function code.
- gnt  out  2  one-hot owner of the ALU; 00 when idle.
- done0  out  1  one-cycle pulse: result for requester 0 valid on res.
- done1  out  1  one-cycle pulse: result for requester 1 valid on res.
- res  out  DW  captured ALU result; holds until the next capture.
- busy  out  1  high in any state other than IDLE.
- alu_a  out  DW  to ALU operand A, registered.
- alu_b  out  DW  to ALU operand B, registered.
- alu_func  out  FW  to ALU function code, registered.
- alu_en  out  1  to ALU enable; high exactly one cycle per operation.
- alu_res  in  DW  from ALU registered result output.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - gnt=00, done0=done1=0, busy=0, alu_en=0.
  - res=0, alu_a=alu_b=0, alu_func=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- The ALU's own enable-out is not used for timing; its latency is fixed at one clock after enable.
- FSM: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - Otherwise select the winner. If only one req is high, that requester wins.
  - If both are high, the winner is the requester not granted last (round robin).
  - On the edge: latch the winner's a/b/func into alu_a/alu_b/alu_func, set gnt one-hot, update last=winner, go to ISSUE.
- ISSUE: alu_en=1 for this cycle only; operands stable. Next state is CAPTURE. The ALU registers its result on this edge.
- CAPTURE: alu_en=0 and alu_res is valid. On the edge, res<=alu_res; next state is DONE.
- DONE:
  - done[gnt]=1 for one cycle; res is valid.
  - On the edge, gnt<=00 and state goes to IDLE.
- Latency: req sampled at edge N, alu_en high in cycle N+1, done high in cycle N+3. Throughput is one operation per 4 cycles.
- Requester rules:
  - A requester holds req until it sees its done.
  - It must deassert req on the edge following done. A req still high in IDLE is treated as a new request.
  - Operands are sampled only at the grant edge and may change afterwards.
- Requests arriving while busy=1 are not sampled. They wait, with no loss, until IDLE.
- A loser held high wins the next arbitration whenever the other requester also re-requests, so there is no starvation.
- Reset mid-operation aborts immediately:
  - No done pulse is issued and the operation is lost.
  - The requester must reissue after reset.
  - The ALU shares rst and clears too.
- alu_a/alu_b/alu_func hold their last values while idle. No function-code decode is done here; codes pass through unchanged.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. Requester 0 always wins a tie; the last pointer is removed.
- Undefined (default): round robin as described above.
- All other timing is identical in both builds.

Test Plan:
- Single request, add: req0=1, a0=16'h0003, b0=16'h0004, func0=3'b001.
  - Expected: gnt=01 from N+1 to N+3.
  - Expected: alu_en high only in N+1.
  - Expected: done0 in N+3 with res=16'h0007; done1 never asserts.
- Tie after reset: req0=req1=1 in the same cycle.
  - Expected: requester 0 served first, with done0.
  - Expected: with req1 held high, requester 1 is granted in the next IDLE, done1 4 cycles after done0.
- Round robin: both requests held continuously.
  - Expected: done0/done1 alternate every 4 cycles across 8 operations.
  - Expected: under ALU_ARB_FIXED_PRIO_EN, when req0 re-requests, grants stay with requester 0.
- Request while busy: req1 asserted in the ISSUE cycle of requester 0's subtract (a0=16'h0005, b0=16'h0007, func0=3'b010).
  - Expected: done0 with res=16'hFFFE (wrap-around).
  - Expected: requester 1 granted on the IDLE edge right after DONE, with no lost request.
- Operand change after grant: change a0 to 16'hFFFF one cycle after the grant edge.
  - Expected: res reflects the originally sampled a0.
- Reset in CAPTURE: pull rst low.
  - Expected: all outputs go to reset values immediately, no done pulse, busy=0.
  - Expected: after release with req0 re-asserted, normal 3-cycle latency resumes.
